// File: rtl/vending_pkg.sv
// Shared types and coin weights for the vending control stage.
package vending_pkg;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    DISPENSE,
    CHANGE
  } state_t;

  localparam int COIN_100_UNITS = 1;
  localparam int COIN_500_UNITS = 5;

endpackage

// File: rtl/vending_if.sv
// Coin/command inputs and registered status outputs of the vending controller.
interface vending_if #(
  parameter int CREDIT_W = 4
);

  logic                coin_100;
  logic                coin_500;
  logic                select;
  logic                cancel;
  logic [CREDIT_W-1:0] credit;
  logic                dispense;
  logic                change_pulse;
  logic                coin_reject;
  logic                deny;
  logic                busy;

  modport master (
    output coin_100, coin_500, select, cancel,
    input  credit, dispense, change_pulse, coin_reject, deny, busy
  );

  modport slave (
    input  coin_100, coin_500, select, cancel,
    output credit, dispense, change_pulse, coin_reject, deny, busy
  );

endinterface

// File: rtl/change_emitter.sv
// Emits load_count single-cycle pulses, each followed by one low cycle;
// done is high once the last low cycle is reached.
module change_emitter #(
  parameter int COUNT_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic [COUNT_W-1:0] load_count,
  output logic               pulse,
  output logic               done
);

  logic [COUNT_W-1:0] remaining;

  // NOTE: clocked state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      remaining <= '0;
      pulse     <= 1'b0;
    end else if (load) begin
      remaining <= load_count;
      pulse     <= (load_count != '0);
    end else if (pulse) begin
      remaining <= remaining - COUNT_W'(1);
      pulse     <= 1'b0;
    end else if (remaining != '0) begin
      pulse <= 1'b1;
    end
  end

  assign done = !pulse && (remaining == '0);

endmodule

// File: rtl/vending_controller.sv
// Vending control stage: credit accumulation, sale/deny, timed dispense and
// credit refund as spaced 100-unit change pulses. All outputs registered.
module vending_controller
  import vending_pkg::*;
#(
  parameter int PRICE_UNITS     = 5,
  parameter int MAX_CREDIT      = 15,
  parameter int CREDIT_W        = 4,
  parameter int DISPENSE_CYCLES = 4
) (
  input  logic     clk,
  input  logic     reset,
  vending_if.slave bus
);

  localparam int TIMER_W = (DISPENSE_CYCLES > 1) ? $clog2(DISPENSE_CYCLES) : 1;
  localparam int SUM_W   = CREDIT_W + 1;
  localparam logic [CREDIT_W-1:0] PRICE      = CREDIT_W'(PRICE_UNITS);
  localparam logic [SUM_W-1:0]    MAX_SUM    = SUM_W'(MAX_CREDIT);
  localparam logic [TIMER_W-1:0]  TIMER_LOAD = TIMER_W'(DISPENSE_CYCLES - 1);

  state_t              state, next_state;
  logic [CREDIT_W-1:0] credit, credit_next;
  logic [TIMER_W-1:0]  timer, timer_next;
  logic                dispense_q, busy_q, reject_q, deny_q;
  logic                dispense_d, busy_d, reject_d, deny_d;
  logic [SUM_W-1:0]    coin_inc, credit_sum;
  logic                coin_any, collecting, over_limit;
  logic                cancel_ok, sale_ok, deny_cond;
  logic                chg_load, chg_pulse, chg_done;

  // Coin sum is formed one bit wider so an overflow is compared, never wrapped.
  assign coin_inc   = (bus.coin_100 ? SUM_W'(COIN_100_UNITS) : '0)
                    + (bus.coin_500 ? SUM_W'(COIN_500_UNITS) : '0);
  assign credit_sum = {1'b0, credit} + coin_inc;
  assign over_limit = credit_sum > MAX_SUM;
  assign coin_any   = bus.coin_100 || bus.coin_500;
  assign collecting = (state == IDLE) || (state == COLLECT);
  assign cancel_ok  = collecting && bus.cancel && (credit != '0);
  assign sale_ok    = collecting && !cancel_ok && bus.select && (credit >= PRICE);
  assign deny_cond  = collecting && !cancel_ok && bus.select && (credit < PRICE);
  assign chg_load   = (next_state == CHANGE) && (state != CHANGE);

  change_emitter #(
    .COUNT_W (CREDIT_W)
  ) u_change (
    .clk        (clk),
    .reset      (reset),
    .load       (chg_load),
    .load_count (credit),
    .pulse      (chg_pulse),
    .done       (chg_done)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      credit     <= '0;
      timer      <= '0;
      dispense_q <= 1'b0;
      busy_q     <= 1'b0;
      reject_q   <= 1'b0;
      deny_q     <= 1'b0;
    end else begin
      state      <= next_state;
      credit     <= credit_next;
      timer      <= timer_next;
      dispense_q <= dispense_d;
      busy_q     <= busy_d;
      reject_q   <= reject_d;
      deny_q     <= deny_d;
    end
  end

  // NOTE: every combinational output is defaulted first so no path infers a latch.
  always_comb begin
    next_state  = state;
    credit_next = credit;
    timer_next  = timer;
    case (state)
      IDLE, COLLECT: begin
        if (cancel_ok) begin
          next_state = CHANGE;
        end else if (sale_ok) begin
          next_state  = DISPENSE;
          credit_next = credit - PRICE;
          timer_next  = TIMER_LOAD;
        end else begin
          if (coin_any && !over_limit) credit_next = credit_sum[CREDIT_W-1:0];
          next_state = (credit_next != '0) ? COLLECT : IDLE;
        end
      end
      DISPENSE: begin
        if (timer == '0) next_state = (credit != '0) ? CHANGE : IDLE;
        else             timer_next = timer - TIMER_W'(1);
      end
      CHANGE: begin
        if (chg_pulse && (credit != '0)) credit_next = credit - CREDIT_W'(1);
        if (chg_done) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    dispense_d = (next_state == DISPENSE);
    busy_d     = (next_state == DISPENSE) || (next_state == CHANGE);
    reject_d   = coin_any && (!collecting || cancel_ok || sale_ok || over_limit);
    deny_d     = deny_cond;
  end

  assign bus.credit       = credit;
  assign bus.dispense     = dispense_q;
  assign bus.busy         = busy_q;
  assign bus.coin_reject  = reject_q;
  assign bus.deny         = deny_q;
  assign bus.change_pulse = chg_pulse;

endmodule
